dac_spi_out: RTL and testbench

- Downstream consumer of the pipelined CORDIC sine generator.
- Captures each 16-bit two's-complement amplitude (sin_amp) when its valid strobe (wen7) is high and buffers it in a small FIFO.
- Converts each sample to DAC code format and shifts it MSB-first over a 3-wire serial DAC interface (sclk/sdo/cs_n), then issues an ldac_n update pulse.
- Decouples the sample rate set by the phase accumulator from the serial-link rate and flags overruns.

---
 rtl/dac_spi_out_if.sv | 28 ++
 rtl/dac_spi_out.sv | 186 ++++++++++++++++++
 tb/tb_dac_spi_out.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_out_if.sv
// Sample input and 3-wire DAC link between the sine source and dac_spi_out.
// master = sample producer / DAC side observer, slave = dac_spi_out.
interface dac_spi_out_if;
  logic [15:0] sin_amp;
  logic        wen7;
  logic        sclk;
  logic        sdo;
  logic        cs_n;
  logic        ldac_n;

  modport master (
    output sin_amp,
    output wen7,
    input  sclk,
    input  sdo,
    input  cs_n,
    input  ldac_n
  );

  modport slave (
    input  sin_amp,
    input  wen7,
    output sclk,
    output sdo,
    output cs_n,
    output ldac_n
  );
endinterface

// File: rtl/dac_spi_out.sv
// dac_spi_out: buffers CORDIC sine samples in a small FIFO, converts them to
// DAC code and shifts them MSB-first over sclk/sdo/cs_n, followed by a
// one-clock ldac_n pulse. Overruns of the FIFO raise a sticky ovf flag.
module dac_spi_out #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int OFFSET_BIN = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          clr_ovf,
  dac_spi_out_if.slave                  dac,
  output logic                          busy,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int HW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HC_MAX_I = CLK_DIV - 1;
  localparam logic [HW-1:0] HC_MAX   = HC_MAX_I[HW-1:0];
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [15:0]    shreg, shreg_nxt;
  logic [HW-1:0]  hc, hc_nxt;
  logic [4:0]     bit_cnt, bit_nxt;
  logic           sclk_nxt, sdo_nxt, cs_n_nxt, ldac_n_nxt;
  logic           pop, push, full, overrun;

  // Two's complement to offset binary is an MSB flip; applied at push time.
  function automatic logic [15:0] to_dac_code(input logic [15:0] amp);
    if (OFFSET_BIN != 0) begin
      return {~amp[15], amp[14:0]};
    end else begin
      return amp;
    end
  endfunction

  assign full    = (fifo_cnt == CNT_FULL);
  assign pop     = (state == ST_IDLE) && en && (fifo_cnt != {(AW+1){1'b0}});
  assign push    = dac.wen7 && (!full || pop);
  assign overrun = dac.wen7 && full && !pop;

  // Sample storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= to_dac_code(dac.sin_amp);
    end
  end

  // FIFO pointers, occupancy and sticky overrun flag (set wins over clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      fifo_cnt <= {(AW+1){1'b0}};
      ovf      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + {{AW{1'b0}}, 1'b1};
        2'b01:   fifo_cnt <= fifo_cnt - {{AW{1'b0}}, 1'b1};
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (overrun) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // State, shift datapath and registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shreg      <= 16'h0000;
      hc         <= {HW{1'b0}};
      bit_cnt    <= 5'd0;
      dac.sclk   <= 1'b0;
      dac.sdo    <= 1'b0;
      dac.cs_n   <= 1'b1;
      dac.ldac_n <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      hc         <= hc_nxt;
      bit_cnt    <= bit_nxt;
      dac.sclk   <= sclk_nxt;
      dac.sdo    <= sdo_nxt;
      dac.cs_n   <= cs_n_nxt;
      dac.ldac_n <= ldac_n_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    hc_nxt     = hc;
    bit_nxt    = bit_cnt;
    sclk_nxt   = 1'b0;
    sdo_nxt    = 1'b0;
    cs_n_nxt   = 1'b1;
    ldac_n_nxt = 1'b1;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          state_nxt = ST_LOAD;
          shreg_nxt = mem[rd_ptr];
          sdo_nxt   = mem[rd_ptr][15];
          cs_n_nxt  = 1'b0;
          hc_nxt    = {HW{1'b0}};
          bit_nxt   = 5'd0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_SHIFT;
        cs_n_nxt  = 1'b0;
        sdo_nxt   = shreg[15];
        hc_nxt    = {HW{1'b0}};
        bit_nxt   = 5'd0;
      end
      ST_SHIFT: begin
        cs_n_nxt = 1'b0;
        sclk_nxt = dac.sclk;
        sdo_nxt  = dac.sdo;
        if (hc == HC_MAX) begin
          hc_nxt = {HW{1'b0}};
          if (!dac.sclk) begin
            // Rising edge: DAC samples the stable sdo.
            sclk_nxt = 1'b1;
          end else begin
            // Falling edge: advance to the next bit.
            sclk_nxt  = 1'b0;
            shreg_nxt = {shreg[14:0], 1'b0};
            sdo_nxt   = shreg[14];
            bit_nxt   = bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state_nxt  = ST_GAP;
              cs_n_nxt   = 1'b1;
              sdo_nxt    = 1'b0;
              ldac_n_nxt = 1'b0;
            end else begin
              state_nxt = ST_SHIFT;
            end
          end
        end else begin
          hc_nxt = hc + {{(HW-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        if (hc == HC_MAX) begin
          state_nxt = ST_IDLE;
          hc_nxt    = {HW{1'b0}};
        end else begin
          hc_nxt = hc + {{(HW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dac_spi_out.sv
// Testbench for dac_spi_out: a cycle-accurate reference built from frame
// timing arithmetic and a sample queue checks DUT A (CLK_DIV=2, offset
// binary); DUT B (CLK_DIV=1, raw) gets a directed single-frame check.
module tb_dac_spi_out;
  localparam int D     = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, en, clr_ovf, busy, ovf;
  logic [2:0] fifo_cnt;
  logic       en_b, clr_b, busy_b, ovf_b;
  logic [2:0] cnt_b;

  dac_spi_out_if bus ();
  dac_spi_out_if bus_b ();

  dac_spi_out #(.CLK_DIV(2), .FIFO_DEPTH(4), .OFFSET_BIN(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .clr_ovf(clr_ovf), .dac(bus),
    .busy(busy), .ovf(ovf), .fifo_cnt(fifo_cnt)
  );

  dac_spi_out #(.CLK_DIV(1), .FIFO_DEPTH(4), .OFFSET_BIN(0)) u_dut_b (
    .clk(clk), .reset(reset), .en(en_b), .clr_ovf(clr_b), .dac(bus_b),
    .busy(busy_b), .ovf(ovf_b), .fifo_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: queued DAC codes, frame age (-1 idle, 1 = load cycle).
  logic [15:0] mq[$];
  int          mt = -1;
  logic [15:0] mword = 16'h0000;
  logic        movf = 1'b0;

  // Serial monitor for the captured word of DUT A.
  logic        prev_sclk = 1'b0;
  logic [15:0] cap = 16'h0000;
  int          rises = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic exp_cs, exp_sclk, exp_sdo, exp_ldac;
    int   bit_idx;
    exp_cs   = !(mt >= 1 && mt <= 1 + 32*D);
    exp_sclk = (mt >= 2 && mt <= 1 + 32*D) ? (((mt - 2) / D) % 2 == 1) : 1'b0;
    bit_idx  = (mt >= 2) ? 15 - ((mt - 2) / (2*D)) : 15;
    exp_sdo  = (mt >= 1 && mt <= 1 + 32*D) ? mword[bit_idx] : 1'b0;
    exp_ldac = !(mt == 2 + 32*D);
    check_eq("cs_n",     bus.cs_n,   exp_cs);
    check_eq("sclk",     bus.sclk,   exp_sclk);
    check_eq("sdo",      bus.sdo,    exp_sdo);
    check_eq("ldac_n",   bus.ldac_n, exp_ldac);
    check_eq("busy",     busy,       (mt >= 1));
    check_eq("fifo_cnt", fifo_cnt,   mq.size());
    check_eq("ovf",      ovf,        movf);
    if (!prev_sclk && bus.sclk) begin
      cap = {cap[14:0], bus.sdo};
      rises++;
    end
    if (!bus.ldac_n) begin
      check_eq("frame_word",  cap,   mword);
      check_eq("frame_rises", rises, 16);
    end
    if (bus.cs_n) rises = 0;
    prev_sclk = bus.sclk;
  endtask

  // Advance one clock: update the reference from pre-edge inputs, then check.
  task automatic cycle();
    logic pop, full, over;
    pop  = (mt < 0) && en && (mq.size() != 0);
    full = (mq.size() == DEPTH);
    over = bus.wen7 && full && !pop;
    if (pop) begin
      mword = mq.pop_front();
      mt    = 1;
    end else if (mt >= 1) begin
      if (mt == 1 + 33*D) mt = -1;
      else mt++;
    end
    if (bus.wen7 && (!full || pop)) mq.push_back(bus.sin_amp + 16'h8000);
    if (over) movf = 1'b1;
    else if (clr_ovf) movf = 1'b0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int          busy_n, cs_low, ldac_cnt, rises_b, last_rise, bad_period;
    logic        prev_b;
    logic [15:0] cap_b;

    reset = 1'b0; en = 1'b0; clr_ovf = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    bus.wen7 = 1'b0; bus.sin_amp = 16'h0000;
    bus_b.wen7 = 1'b0; bus_b.sin_amp = 16'h0000;
    #22;
    compare_all();
    check_eq("b_rst_cs_n", bus_b.cs_n, 1'b1);
    check_eq("b_rst_cnt",  cnt_b,      3'd0);
    @(negedge clk) reset = 1'b1;

    // Single zero sample -> 0x8000 frame.
    en = 1'b1; bus.sin_amp = 16'h0000; bus.wen7 = 1'b1;
    cycle();
    bus.wen7 = 1'b0;
    repeat (75) cycle();

    // Back-to-back samples, no idle gap between frames.
    bus.wen7 = 1'b1; bus.sin_amp = 16'h7FFF; cycle();
    bus.sin_amp = 16'h8001; cycle();
    bus.wen7 = 1'b0;
    repeat (150) cycle();

    // Overfill with en low; 5th push coincides with clr_ovf (set wins).
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wen7 = 1'b1; bus.sin_amp = 16'($urandom);
      clr_ovf = (i == 4);
      cycle();
    end
    bus.wen7 = 1'b0; clr_ovf = 1'b0;
    repeat (2) cycle();
    clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
    repeat (2) cycle();

    // Full FIFO: pop and push in the same cycle.
    en = 1'b1; bus.wen7 = 1'b1; bus.sin_amp = 16'($urandom);
    cycle();
    bus.wen7 = 1'b0;
    repeat (4*68 + 10) cycle();

    // Reset in the middle of bit 7 with one sample still queued.
    bus.wen7 = 1'b1; bus.sin_amp = 16'($urandom); cycle();
    bus.sin_amp = 16'($urandom); cycle();
    bus.wen7 = 1'b0;
    for (int i = 0; i < 200 && mt != 2 + 14*D; i++) cycle();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_cs_n",  bus.cs_n,   1'b1);
    check_eq("rst_sclk",  bus.sclk,   1'b0);
    check_eq("rst_cnt",   fifo_cnt,   3'd0);
    check_eq("rst_busy",  busy,       1'b0);
    check_eq("rst_ldac",  bus.ldac_n, 1'b1);
    mq.delete(); mt = -1; movf = 1'b0; prev_sclk = 1'b0; rises = 0;
    @(negedge clk) reset = 1'b1;
    repeat (80) cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      bus.wen7 = ($urandom_range(0, 39) == 0);
      bus.sin_amp = 16'($urandom);
      clr_ovf  = ($urandom_range(0, 99) == 0);
      cycle();
    end
    en = 1'b0; bus.wen7 = 1'b0; clr_ovf = 1'b0;
    repeat (3) cycle();

    // DUT B: raw 0xA5A5 at CLK_DIV=1 -> 35-clock frame, sclk period 2.
    bus_b.sin_amp = 16'hA5A5; bus_b.wen7 = 1'b1; en_b = 1'b1;
    @(posedge clk); #1;
    bus_b.wen7 = 1'b0;
    busy_n = 0; cs_low = 0; ldac_cnt = 0; rises_b = 0; last_rise = -1;
    bad_period = 0; prev_b = 1'b0; cap_b = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy_b) busy_n++;
      if (!bus_b.cs_n) cs_low++;
      if (!bus_b.ldac_n) ldac_cnt++;
      if (!prev_b && bus_b.sclk) begin
        cap_b = {cap_b[14:0], bus_b.sdo};
        if (last_rise >= 0 && i - last_rise != 2) bad_period++;
        last_rise = i;
        rises_b++;
      end
      prev_b = bus_b.sclk;
    end
    check_eq("b_word",       cap_b,      16'hA5A5);
    check_eq("b_busy_len",   busy_n,     34);
    check_eq("b_cs_low",     cs_low,     33);
    check_eq("b_ldac_cnt",   ldac_cnt,   1);
    check_eq("b_rises",      rises_b,    16);
    check_eq("b_period_bad", bad_period, 0);
    check_eq("b_cnt_end",    cnt_b,      3'd0);
    check_eq("b_ovf",        ovf_b,      1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
